// File: rtl/carfield_mbox_pkg.sv
// ============================================================================
// carfield_mbox_pkg
// Shared types and helpers for the security-island mailbox scheduler.
// Revision: 1.0
// ============================================================================
`default_nettype none

package carfield_mbox_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_POST = 2'd1,
        ST_WAIT = 2'd2
    } state_e;

    // Width able to hold 0..cycles; never narrower than one bit.
    function automatic int cnt_width(input int unsigned cycles);
        return (cycles == 0) ? 1 : $clog2(cycles + 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/carfield_mbox_rr_pick.sv
// ============================================================================
// carfield_mbox_rr_pick
// Combinational round-robin picker: first valid requester at or after ptr_i.
// Revision: 1.0
// ============================================================================
`default_nettype none

module carfield_mbox_rr_pick #(
    parameter int NumReq  = 4,
    parameter int IdWidth = $clog2(NumReq)
) (
    input  logic [NumReq-1:0]  valid_i,
    input  logic [IdWidth-1:0] ptr_i,
    output logic [NumReq-1:0]  grant_o,
    output logic [IdWidth-1:0] id_o
);

    int unsigned w_idx;
    logic        w_found;

    always_comb begin
        grant_o = '0;
        id_o    = '0;
        w_found = 1'b0;
        w_idx   = 0;
        for (int i = 0; i < NumReq; i++) begin
            w_idx = (int'(ptr_i) + i) % NumReq;
            if (!w_found && valid_i[w_idx]) begin
                w_found        = 1'b1;
                grant_o[w_idx] = 1'b1;
                id_o           = IdWidth'(w_idx);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/carfield_mbox_sched.sv
// ============================================================================
// carfield_mbox_sched
// Round-robin sharing of one mailbox slot with doorbell IRQ, ack and timeout.
// Revision: 1.0
// ============================================================================
`default_nettype none

module carfield_mbox_sched
    import carfield_mbox_pkg::*;
#(
    parameter int          NumReq        = 4,
    parameter int          DataWidth     = 32,
    parameter int unsigned TimeoutCycles = 1024,
    localparam int         IdWidth       = $clog2(NumReq)
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic [NumReq-1:0]                req_valid_i,
    output logic [NumReq-1:0]                req_ready_o,
    input  logic [NumReq-1:0][DataWidth-1:0] req_data_i,
    output logic [DataWidth-1:0]             mbox_letter_o,
    output logic [IdWidth-1:0]               mbox_sender_o,
    output logic                             mbox_irq_o,
    input  logic                             mbox_ack_i,
    output logic [NumReq-1:0]                done_o,
    output logic [NumReq-1:0]                err_o,
    output logic                             busy_o
);

    localparam int          CNT_W   = cnt_width(TimeoutCycles);
    localparam int unsigned TO_LAST = (TimeoutCycles == 0) ? 0 : TimeoutCycles - 1;

    state_e                r_state;
    state_e                w_next;
    logic [IdWidth-1:0]    r_ptr;
    logic [CNT_W-1:0]      r_cnt;
    logic [DataWidth-1:0]  r_letter;
    logic [IdWidth-1:0]    r_sender;
    logic [NumReq-1:0]     r_done;
    logic [NumReq-1:0]     r_err;

    logic [NumReq-1:0]     w_grant;
    logic [IdWidth-1:0]    w_win_id;
    logic                  w_hs;
    logic                  w_timeout;
    logic                  w_fin_done;
    logic                  w_fin_err;
    logic [IdWidth-1:0]    w_next_ptr;

    carfield_mbox_rr_pick #(
        .NumReq  (NumReq),
        .IdWidth (IdWidth)
    ) u_rr_pick (
        .valid_i (req_valid_i),
        .ptr_i   (r_ptr),
        .grant_o (w_grant),
        .id_o    (w_win_id)
    );

    // Timeout fires on the last allowed WAIT cycle; disabled entirely when TimeoutCycles is 0.
    assign w_timeout  = (TimeoutCycles != 0) && (r_cnt == CNT_W'(TO_LAST));
    assign w_next_ptr = (r_sender == IdWidth'(NumReq - 1)) ? '0 : r_sender + IdWidth'(1);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state  <= ST_IDLE;
            r_ptr    <= '0;
            r_cnt    <= '0;
            r_letter <= '0;
            r_sender <= '0;
            r_done   <= '0;
            r_err    <= '0;
        end else begin
            r_state <= w_next;
            r_done  <= '0;
            r_err   <= '0;
            if (w_hs) begin
                r_letter <= req_data_i[w_win_id];
                r_sender <= w_win_id;
            end
            if (r_state == ST_POST) begin
                r_cnt <= '0;
            end else if ((r_state == ST_WAIT) && (r_cnt != {CNT_W{1'b1}})) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
            if (w_fin_done) begin
                r_done <= NumReq'(1) << r_sender;
                r_ptr  <= w_next_ptr;
            end else if (w_fin_err) begin
                r_err <= NumReq'(1) << r_sender;
                r_ptr <= w_next_ptr;
            end
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (w_hs) w_next = ST_POST;
            ST_POST: w_next = ST_WAIT;
            ST_WAIT: if (mbox_ack_i || w_timeout) w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    // Ack has priority over a coincident timeout.
    always_comb begin
        req_ready_o = (r_state == ST_IDLE) ? w_grant : '0;
        w_hs        = (r_state == ST_IDLE) && (|w_grant);
        w_fin_done  = (r_state == ST_WAIT) && mbox_ack_i;
        w_fin_err   = (r_state == ST_WAIT) && !mbox_ack_i && w_timeout;
        mbox_irq_o  = (r_state == ST_WAIT);
        busy_o      = (r_state != ST_IDLE);
    end

    assign mbox_letter_o = r_letter;
    assign mbox_sender_o = r_sender;
    assign done_o        = r_done;
    assign err_o         = r_err;

endmodule

`default_nettype wire

// File: tb/tb_carfield_mbox_sched.sv
// ============================================================================
// tb_carfield_mbox_sched
// Scoreboard bench: stimulus queues expected grants/completions, monitor checks.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_carfield_mbox_sched;

    localparam int N  = 4;
    localparam int DW = 32;

    logic                clk = 1'b0;
    logic                rst;
    logic [N-1:0]        valid;
    logic [N-1:0]        ready;
    logic [N-1:0][DW-1:0] data;
    logic [DW-1:0]       letter;
    logic [1:0]          sender;
    logic                irq;
    logic                ack;
    logic [N-1:0]        done;
    logic [N-1:0]        err;
    logic                busy;

    carfield_mbox_sched #(
        .NumReq        (N),
        .DataWidth     (DW),
        .TimeoutCycles (16)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .req_valid_i   (valid),
        .req_ready_o   (ready),
        .req_data_i    (data),
        .mbox_letter_o (letter),
        .mbox_sender_o (sender),
        .mbox_irq_o    (irq),
        .mbox_ack_i    (ack),
        .done_o        (done),
        .err_o         (err),
        .busy_o        (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int id;
        bit after_ack;
    } grant_t;

    typedef struct {
        logic [N-1:0]  done;
        logic [N-1:0]  err;
        int            sender;
        logic [DW-1:0] letter;
        int            lat;
    } fin_t;

    grant_t exp_grant[$];
    fin_t   exp_fin[$];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int t_hs   = 0;
    int t_irq  = 0;
    int t_ack  = -100;
    logic prev_irq = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: samples mid-cycle and pops the scoreboard on every grant/completion.
    always @(negedge clk) begin
        if (rst) begin
            prev_irq = 1'b0;
        end else begin
            grant_t g;
            fin_t   f;
            logic [N-1:0] hs;
            if (!$onehot0(ready)) chk("ready_onehot", ready, 0);
            if (busy && (|ready)) chk("ready_outside_idle", ready, 0);
            hs = valid & ready;
            if (|hs) begin
                if (exp_grant.size() == 0) begin
                    chk("unexpected_grant", hs, 0);
                end else begin
                    g = exp_grant.pop_front();
                    chk("grant_id", hs, 64'(N'(1) << g.id));
                    if (g.after_ack) chk("grant_after_ack_lat", cyc, t_ack + 1);
                end
                t_hs = cyc;
            end
            if (irq && !prev_irq) begin
                chk("irq_lat", cyc, t_hs + 2);
                t_irq = cyc;
            end
            if (ack && irq) t_ack = cyc;
            if ((|done) || (|err)) begin
                if (exp_fin.size() == 0) begin
                    chk("unexpected_pulse", {done, err}, 0);
                end else begin
                    f = exp_fin.pop_front();
                    chk("done", done, f.done);
                    chk("err", err, f.err);
                    chk("sender", sender, f.sender);
                    chk("letter", letter, f.letter);
                    chk("irq_low_at_pulse", irq, 0);
                    if (f.lat != 0) chk("pulse_lat", cyc - t_irq, f.lat);
                    if (|f.done) chk("done_after_ack", cyc, t_ack + 1);
                end
            end
            prev_irq = irq;
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_irq(input bit level);
        for (int i = 0; i < 100; i++) begin
            if (irq === level) return;
            tick();
        end
        chk("wait_irq_timeout", irq, level);
    endtask

    task automatic pulse_ack();
        ack = 1'b1;
        tick();
        ack = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    function automatic fin_t mk_fin(input int id, input bit is_err, input int lat);
        fin_t f;
        f.done   = is_err ? '0 : N'(1) << id;
        f.err    = is_err ? N'(1) << id : '0;
        f.sender = id;
        f.letter = data[id];
        f.lat    = lat;
        return f;
    endfunction

    initial begin
        rst   = 1'b1;
        valid = '0;
        ack   = 1'b0;
        data[0] = 32'hCAFE0001;
        data[1] = 32'h1111_0002;
        data[2] = 32'h2222_0003;
        data[3] = 32'h3333_0004;
        do_reset();

        // Reset state
        chk("rst_ready", ready, 0);
        chk("rst_irq", irq, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done_err", {done, err}, 0);
        chk("rst_letter", letter, 0);
        chk("rst_sender", sender, 0);

        // Single post, ack 5 cycles after irq
        exp_grant.push_back('{0, 1'b0});
        exp_fin.push_back(mk_fin(0, 1'b0, 6));
        valid[0] = 1'b1;
        wait_irq(1'b1);
        valid[0] = 1'b0;
        chk("post_busy", busy, 1);
        repeat (5) tick();
        pulse_ack();
        tick();
        chk("single_irq_low", irq, 0);
        chk("letter_hold", letter, 32'hCAFE0001);

        // Fairness from pointer 0 with immediate acks
        do_reset();
        for (int k = 0; k < 5; k++) begin
            exp_grant.push_back('{k % N, 1'b0});
            exp_fin.push_back(mk_fin(k % N, 1'b0, 1));
        end
        valid = '1;
        for (int k = 0; k < 5; k++) begin
            wait_irq(1'b1);
            ack = 1'b1;
            tick();
            ack   = 1'b0;
            if (k == 4) valid = '0;
        end
        tick();

        // Timeout on requester 1 (pointer now 1)
        exp_grant.push_back('{1, 1'b0});
        exp_fin.push_back(mk_fin(1, 1'b1, 16));
        valid[1] = 1'b1;
        wait_irq(1'b1);
        valid[1] = 1'b0;
        wait_irq(1'b0);
        tick();

        // Ack coincident with the timeout cycle: done wins (pointer now 2)
        exp_grant.push_back('{2, 1'b0});
        exp_fin.push_back(mk_fin(2, 1'b0, 16));
        valid[2] = 1'b1;
        wait_irq(1'b1);
        valid[2] = 1'b0;
        repeat (15) tick();
        pulse_ack();
        tick();

        // Spurious ack in IDLE
        pulse_ack();
        chk("spurious_busy", busy, 0);
        chk("spurious_irq", irq, 0);
        tick();

        // Pointer 3 wraps to requester 0; req2 waits and wins at A+1
        exp_grant.push_back('{0, 1'b0});
        exp_fin.push_back(mk_fin(0, 1'b0, 4));
        exp_grant.push_back('{2, 1'b1});
        exp_fin.push_back(mk_fin(2, 1'b0, 2));
        valid[0] = 1'b1;
        wait_irq(1'b1);
        valid[0] = 1'b0;
        valid[2] = 1'b1;
        repeat (3) tick();
        pulse_ack();
        wait_irq(1'b1);
        valid[2] = 1'b0;
        tick();
        pulse_ack();
        tick();

        // Reset mid-WAIT (pointer 3 -> wins req1), then pointer back to 0
        exp_grant.push_back('{1, 1'b0});
        valid[1] = 1'b1;
        wait_irq(1'b1);
        valid[1] = 1'b0;
        repeat (3) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midwait_rst_irq", irq, 0);
        chk("midwait_rst_busy", busy, 0);
        exp_grant.push_back('{1, 1'b0});
        exp_fin.push_back(mk_fin(1, 1'b0, 0));
        valid[3] = 1'b1;
        valid[1] = 1'b1;
        wait_irq(1'b1);
        valid = '0;
        pulse_ack();
        repeat (3) tick();

        chk("grants_left", exp_grant.size(), 0);
        chk("pulses_left", exp_fin.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
